dmem_responder: RTL

- Data-memory responder: the far end of the load/store interface whose requests come from the core's control decoder (mem_read, mem_write, func3 size).
- Accepts one load or store at a time, waits a configurable number of cycles, commits or reads the word-array storage, and returns a one-cycle mem_ready pulse with aligned and extended read data.
- Sits between the ALU address output and the register-file writeback mux.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: func3 size codes, FSM state encoding and misalignment helper for dmem_responder.
// Latency: none, constants and a pure function only.
// Backpressure: not applicable.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    INIT = 2'd3
  } state_t;

  // Unknown size codes are rejected the same way as unaligned ones.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = off[0];
      F3_W:        is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load lane select/extension and store byte-enable/data shifting.
// Latency: purely combinational.
// Backpressure: none; the caller gates byte_en on misalignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data
);

  logic [31:0] rd_shift;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  assign rd_shift = rd_word >> {byte_off, 3'b000};
  assign rd_b     = rd_shift[7:0];
  assign rd_h     = rd_shift[15:0];

  // Load path: pick the addressed lane(s) then extend according to func3.
  always_comb begin
    load_data = '0;
    case (func3)
      F3_B:    load_data = {{24{rd_b[7]}}, rd_b};
      F3_BU:   load_data = {24'd0, rd_b};
      F3_H:    load_data = {{16{rd_h[15]}}, rd_h};
      F3_HU:   load_data = {16'd0, rd_h};
      F3_W:    load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Store path: move the low byte/half into its lane and raise matching enables.
  always_comb begin
    byte_en    = '0;
    store_data = wr_data << {byte_off, 3'b000};
    case (func3[1:0])
      2'b00:   byte_en = 4'b0001 << byte_off;
      2'b01:   byte_en = 4'b0011 << byte_off;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder over a word array (DMEM_ZERO_INIT_EN adds clear-on-reset).
// Latency: request accepted at edge N gives a one-cycle mem_ready in cycle N+LATENCY+1.
// Backpressure: none queued; requests are only sampled in IDLE and busy flags every other state.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        misaligned,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_ZERO_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          is_wr;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   word_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          access;
  logic          mis;
  logic [AW-1:0] idx;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   store_data;
  logic          addr_unused;

  // Upper address bits alias onto the array, so they are deliberately dropped.
  assign addr_unused = ^addr[31:AW+2];

  assign req    = mem_read | mem_write;
  assign access = (state == WAIT) && (cnt == '0);
  assign mis    = is_misaligned(f3_q, addr_q[1:0]);
  assign idx    = addr_q[AW+1:2];

  dmem_lane_align u_align (
    .func3      (f3_q),
    .byte_off   (addr_q[1:0]),
    .rd_word    (word_q),
    .wr_data    (wdata_q),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_data (store_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // Capture the request in IDLE and count down the wait while in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_wr   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      cnt     <= 4'(LATENCY - 1);
      is_wr   <= mem_write;
      f3_q    <= func3;
      addr_q  <= addr[AW+1:0];
      wdata_q <= write_data;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef DMEM_ZERO_INIT_EN
  logic [AW-1:0] init_idx;

  // Clear pointer walks the array once per reset.
  always_ff @(posedge clk) begin
    if (!rst_n)              init_idx <= '0;
    else if (state == INIT)  init_idx <= init_idx + AW'(1);
  end
`endif

  // Storage: read the word and commit byte-enabled stores on the final WAIT edge; reset blocks the commit.
  always_ff @(posedge clk) begin
    if (rst_n && access) begin
      word_q <= mem[idx];
      if (is_wr && !mis) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
`ifdef DMEM_ZERO_INIT_EN
    if (rst_n && state == INIT) mem[init_idx] <= '0;
`endif
  end

  // Next state and Moore outputs; data only leaves the block during DONE.
  always_comb begin
    state_nxt  = state;
    mem_ready  = 1'b0;
    misaligned = 1'b0;
    read_data  = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt  = IDLE;
        mem_ready  = 1'b1;
        misaligned = mis;
        read_data  = (mis || is_wr) ? 32'd0 : load_data;
      end
      INIT: begin
`ifdef DMEM_ZERO_INIT_EN
        if (init_idx == AW'(DEPTH_WORDS - 1)) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
